// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-serial data-memory controller between the MEM stage,
// an 8-bit data RAM and a direct-mapped write-through data cache.
// Aligned word loads that hit the cache finish in one cycle; everything
// else walks the RAM one byte per cycle, refilling the cache on word loads.
module dmem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic [31:0] cache_raddr,
   input  logic        cache_hit,
   input  logic [31:0] cache_data,
   output logic        cache_we,
   output logic [2:0]  cache_wtype,
   output logic [31:0] cache_waddr,
   output logic [7:0]  cache_wdata,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2, DONE = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [2:0]  func3_q, func3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  cnt_q, cnt_d;

   logic [2:0]  nbytes;
   logic [31:0] cnt_addr;
   logic [31:0] asm_merged;
   logic [7:0]  store_byte;

   function automatic logic [2:0] byte_count(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'd0, w[7:0]};
         3'b101:  return {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   assign nbytes      = byte_count(func3_q[1:0]);
   assign cnt_addr    = addr_q + {29'd0, cnt_q};
   assign req_ready   = (state_q == IDLE);
   assign done        = (state_q == DONE);
   assign rdata       = rdata_q;
   assign cache_raddr = req_addr;

   // Assembly register with the byte arriving this cycle already merged in,
   // so the final byte can feed the extended result without an extra cycle.
   always_comb begin
      asm_merged = asm_q;
      if (state_q == LOAD) begin
         case (cnt_q)
            3'd1:    asm_merged[7:0]   = ram_din;
            3'd2:    asm_merged[15:8]  = ram_din;
            3'd3:    asm_merged[23:16] = ram_din;
            3'd4:    asm_merged[31:24] = ram_din;
            default: ;
         endcase
      end
   end

   // Store data byte selected by the byte counter.
   always_comb begin
      case (cnt_q[1:0])
         2'd0:    store_byte = wdata_q[7:0];
         2'd1:    store_byte = wdata_q[15:8];
         2'd2:    store_byte = wdata_q[23:16];
         default: store_byte = wdata_q[31:24];
      endcase
   end

   // Next-state logic: request acceptance, byte counting and result capture.
   always_comb begin
      state_d = state_q;
      func3_d = func3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               func3_d = req_func3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 3'd0;
               asm_d   = 32'd0;
               if (is_illegal(req_we, req_func3)) begin
                  rdata_d = 32'd0;
                  state_d = DONE;
               end else if (!req_we && (req_func3 == 3'b010) && cache_hit) begin
                  rdata_d = cache_data;
                  state_d = DONE;
               end else if (req_we) begin
                  state_d = STORE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            asm_d = asm_merged;
            if (cnt_q == nbytes) begin
               rdata_d = extend(func3_q, asm_merged);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         STORE: begin
            if (cnt_q == nbytes - 3'd1) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM and cache strobes decoded from state and counter; idle otherwise.
   always_comb begin
      ram_we      = 1'b0;
      ram_addr    = 32'd0;
      ram_dout    = 8'd0;
      cache_we    = 1'b0;
      cache_wtype = 3'd0;
      cache_waddr = 32'd0;
      cache_wdata = 8'd0;
      case (state_q)
         LOAD: begin
            if (cnt_q < nbytes) begin
               ram_addr = cnt_addr;
            end
            if ((func3_q == 3'b010) && (cnt_q != 3'd0)) begin
               cache_we    = 1'b1;
               cache_wtype = 3'b010;
               cache_waddr = cnt_addr - 32'd1;
               cache_wdata = ram_din;
            end
         end
         STORE: begin
            ram_we      = 1'b1;
            ram_addr    = cnt_addr;
            ram_dout    = store_byte;
            cache_we    = 1'b1;
            cache_wtype = func3_q;
            cache_waddr = cnt_addr;
            cache_wdata = store_byte;
         end
         default: ;
      endcase
   end

   // State register; asynchronous reset returns everything to IDLE at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         func3_q <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         asm_q   <= 32'd0;
         rdata_q <= 32'd0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         func3_q <= func3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with a 256-byte RAM model and a
// testbench-driven cache read port.
module tb_dmem_ctrl;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqWe;
   logic [2:0]  reqFunc3;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        doneSig;
   logic [31:0] rdataSig;
   logic [31:0] cacheRaddr;
   logic        cacheHit;
   logic [31:0] cacheData;
   logic        cacheWe;
   logic [2:0]  cacheWtype;
   logic [31:0] cacheWaddr;
   logic [7:0]  cacheWdata;
   logic [31:0] ramAddr;
   logic        ramWe;
   logic [7:0]  ramDout;
   logic [7:0]  ramDin;

   logic [7:0]  mem [256];
   logic        pokeEn;
   logic [7:0]  pokeAddr;
   logic [7:0]  pokeData;

   int          vecCount;
   int          errCount;

   localparam int MAXC = 16;
   logic [31:0] tRamAddr   [MAXC];
   logic        tRamWe     [MAXC];
   logic [7:0]  tRamDout   [MAXC];
   logic        tCacheWe   [MAXC];
   logic [2:0]  tWtype     [MAXC];
   logic [31:0] tWaddr     [MAXC];
   logic [7:0]  tWdata     [MAXC];
   logic        tReady     [MAXC];
   logic [31:0] tRaddr0;
   logic [31:0] rdataAtDone;
   int          doneCyc;

   dmem_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (reqValid),
      .req_ready   (reqReady),
      .req_we      (reqWe),
      .req_func3   (reqFunc3),
      .req_addr    (reqAddr),
      .req_wdata   (reqWdata),
      .done        (doneSig),
      .rdata       (rdataSig),
      .cache_raddr (cacheRaddr),
      .cache_hit   (cacheHit),
      .cache_data  (cacheData),
      .cache_we    (cacheWe),
      .cache_wtype (cacheWtype),
      .cache_waddr (cacheWaddr),
      .cache_wdata (cacheWdata),
      .ram_addr    (ramAddr),
      .ram_we      (ramWe),
      .ram_dout    (ramDout),
      .ram_din     (ramDin)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte-wide RAM model: synchronous write, read data one cycle after address.
   always @(posedge clk) begin
      if (ramWe) begin
         mem[ramAddr[7:0]] <= ramDout;
      end else if (pokeEn) begin
         mem[pokeAddr] <= pokeData;
      end
      ramDin <= mem[ramAddr[7:0]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pokeByte(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pokeEn   = 1'b1;
      pokeAddr = a;
      pokeData = d;
      @(posedge clk);
      #1 pokeEn = 1'b0;
   endtask

   function automatic int countRamWe();
      int n = 0;
      for (int k = 0; k < MAXC; k++) n += int'(tRamWe[k]);
      return n;
   endfunction

   function automatic int countCacheWe();
      int n = 0;
      for (int k = 0; k < MAXC; k++) n += int'(tCacheWe[k]);
      return n;
   endfunction

   // Issue one request at T0 and trace outputs at each negedge until one cycle past done.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic hit, input logic [31:0] cdata);
      for (int k = 0; k < MAXC; k++) begin
         tRamAddr[k] = '0; tRamWe[k] = 1'b0; tRamDout[k] = '0; tCacheWe[k] = 1'b0;
         tWtype[k] = '0; tWaddr[k] = '0; tWdata[k] = '0; tReady[k] = 1'b0;
      end
      doneCyc     = -1;
      rdataAtDone = 32'hXXXXXXXX;
      @(negedge clk);
      reqWe     = we;
      reqFunc3  = f3;
      reqAddr   = addr;
      reqWdata  = wd;
      cacheHit  = hit;
      cacheData = cdata;
      reqValid  = 1'b1;
      #1;
      tReady[0] = reqReady;
      tRaddr0   = cacheRaddr;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      cacheHit = 1'b0;
      for (int k = 1; k < MAXC; k++) begin
         @(negedge clk);
         tRamAddr[k] = ramAddr;
         tRamWe[k]   = ramWe;
         tRamDout[k] = ramDout;
         tCacheWe[k] = cacheWe;
         tWtype[k]   = cacheWtype;
         tWaddr[k]   = cacheWaddr;
         tWdata[k]   = cacheWdata;
         tReady[k]   = reqReady;
         if (doneSig && doneCyc < 0) begin
            doneCyc     = k;
            rdataAtDone = rdataSig;
         end
         if (doneCyc >= 0 && k == doneCyc + 1) break;
      end
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      logic [7:0] lwBytes [4];
      vecCount = 0;
      errCount = 0;
      rst      = 1'b0;
      reqValid = 1'b0;
      reqWe    = 1'b0;
      reqFunc3 = 3'd0;
      reqAddr  = 32'd0;
      reqWdata = 32'd0;
      cacheHit = 1'b0;
      cacheData = 32'd0;
      pokeEn   = 1'b0;
      pokeAddr = 8'd0;
      pokeData = 8'd0;
      lwBytes  = '{8'h11, 8'h22, 8'h33, 8'h44};

      repeat (3) @(negedge clk);
      checkOutput("reset req_ready", 32'(reqReady), 32'd1);
      checkOutput("reset done", 32'(doneSig), 32'd0);
      checkOutput("reset rdata", rdataSig, 32'd0);
      checkOutput("reset ram_we", 32'(ramWe), 32'd0);
      checkOutput("reset cache_we", 32'(cacheWe), 32'd0);
      checkOutput("reset ram_addr", ramAddr, 32'd0);
      checkOutput("reset cache_wtype", 32'(cacheWtype), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) pokeByte(8'(i), lwBytes[i]);
      pokeByte(8'h07, 8'h80);
      pokeByte(8'h10, 8'h01);
      pokeByte(8'h11, 8'h02);
      pokeByte(8'h12, 8'h03);
      pokeByte(8'h13, 8'h84);
      pokeByte(8'h41, 8'hEE);

      $display("[TB] LW hit at 0x100");
      applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 32'hDEADBEEF);
      checkOutput("lwhit ready T0", 32'(tReady[0]), 32'd1);
      checkOutput("lwhit cache_raddr", tRaddr0, 32'h100);
      checkOutput("lwhit done cycle", 32'(doneCyc), 32'd1);
      checkOutput("lwhit rdata", rdataAtDone, 32'hDEADBEEF);
      checkOutput("lwhit ram_we count", 32'(countRamWe()), 32'd0);
      checkOutput("lwhit ready T2", 32'(tReady[2]), 32'd1);

      $display("[TB] LW miss at 0x200");
      applyStimulus(1'b0, 3'b010, 32'h200, 32'd0, 1'b0, 32'd0);
      for (int k = 1; k <= 4; k++)
         checkOutput($sformatf("lwmiss ram_addr T%0d", k), tRamAddr[k], 32'h200 + 32'(k - 1));
      checkOutput("lwmiss cache_we T1", 32'(tCacheWe[1]), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         checkOutput($sformatf("lwmiss cache_we T%0d", k), 32'(tCacheWe[k]), 32'd1);
         checkOutput($sformatf("lwmiss wtype T%0d", k), 32'(tWtype[k]), 32'd2);
         checkOutput($sformatf("lwmiss waddr T%0d", k), tWaddr[k], 32'h200 + 32'(k - 2));
         checkOutput($sformatf("lwmiss wdata T%0d", k), 32'(tWdata[k]), 32'(lwBytes[k - 2]));
      end
      checkOutput("lwmiss done cycle", 32'(doneCyc), 32'd6);
      checkOutput("lwmiss rdata", rdataAtDone, 32'h44332211);
      checkOutput("lwmiss ram_we count", 32'(countRamWe()), 32'd0);

      $display("[TB] LB / LBU at 0x7");
      applyStimulus(1'b0, 3'b000, 32'h7, 32'd0, 1'b0, 32'd0);
      checkOutput("lb ram_addr T1", tRamAddr[1], 32'h7);
      checkOutput("lb done cycle", 32'(doneCyc), 32'd3);
      checkOutput("lb rdata", rdataAtDone, 32'hFFFFFF80);
      checkOutput("lb cache_we count", 32'(countCacheWe()), 32'd0);
      applyStimulus(1'b0, 3'b100, 32'h7, 32'd0, 1'b0, 32'd0);
      checkOutput("lbu done cycle", 32'(doneCyc), 32'd3);
      checkOutput("lbu rdata", rdataAtDone, 32'h00000080);
      checkOutput("lbu cache_we count", 32'(countCacheWe()), 32'd0);

      $display("[TB] SH across address wrap");
      applyStimulus(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 1'b0, 32'd0);
      checkOutput("sh ram_we T1", 32'(tRamWe[1]), 32'd1);
      checkOutput("sh ram_addr T1", tRamAddr[1], 32'hFFFFFFFF);
      checkOutput("sh ram_dout T1", 32'(tRamDout[1]), 32'hCD);
      checkOutput("sh ram_addr T2", tRamAddr[2], 32'h0);
      checkOutput("sh ram_dout T2", 32'(tRamDout[2]), 32'hAB);
      checkOutput("sh cache_we T1", 32'(tCacheWe[1]), 32'd1);
      checkOutput("sh wtype T1", 32'(tWtype[1]), 32'd1);
      checkOutput("sh waddr T1", tWaddr[1], 32'hFFFFFFFF);
      checkOutput("sh wdata T1", 32'(tWdata[1]), 32'hCD);
      checkOutput("sh wtype T2", 32'(tWtype[2]), 32'd1);
      checkOutput("sh waddr T2", tWaddr[2], 32'h0);
      checkOutput("sh wdata T2", 32'(tWdata[2]), 32'hAB);
      checkOutput("sh done cycle", 32'(doneCyc), 32'd3);
      checkOutput("sh ram_we count", 32'(countRamWe()), 32'd2);
      checkOutput("sh rdata held", rdataAtDone, 32'h00000080);
      checkOutput("sh mem 0xFF", 32'(mem[8'hFF]), 32'hCD);
      checkOutput("sh mem 0x00", 32'(mem[8'h00]), 32'hAB);

      $display("[TB] Reset in the middle of SW");
      @(negedge clk);
      reqWe    = 1'b1;
      reqFunc3 = 3'b010;
      reqAddr  = 32'h40;
      reqWdata = 32'h12345678;
      reqValid = 1'b1;
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(negedge clk);
      checkOutput("sw T1 ram_we", 32'(ramWe), 32'd1);
      checkOutput("sw T1 ram_dout", 32'(ramDout), 32'h78);
      @(posedge clk);
      #2;
      checkOutput("sw T2 ram_we", 32'(ramWe), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("sw rst ram_we", 32'(ramWe), 32'd0);
      checkOutput("sw rst cache_we", 32'(cacheWe), 32'd0);
      checkOutput("sw rst req_ready", 32'(reqReady), 32'd1);
      checkOutput("sw rst ram_addr", ramAddr, 32'd0);
      checkOutput("sw rst rdata", rdataSig, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      checkOutput("sw mem 0x40", 32'(mem[8'h40]), 32'h78);
      checkOutput("sw mem 0x41", 32'(mem[8'h41]), 32'hEE);

      $display("[TB] LW miss at 0x10 after reset");
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'd0);
      checkOutput("lw2 done cycle", 32'(doneCyc), 32'd6);
      checkOutput("lw2 rdata", rdataAtDone, 32'h84030201);
      checkOutput("lw2 cache_we count", 32'(countCacheWe()), 32'd4);

      $display("[TB] Illegal func3 011 load");
      applyStimulus(1'b0, 3'b011, 32'h20, 32'd0, 1'b0, 32'd0);
      checkOutput("illegal done cycle", 32'(doneCyc), 32'd1);
      checkOutput("illegal rdata", rdataAtDone, 32'd0);
      checkOutput("illegal ram_we count", 32'(countRamWe()), 32'd0);
      checkOutput("illegal cache_we count", 32'(countCacheWe()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
